// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage with single-outstanding req/ack data port
// Optional misalignment trap: define MEM_MISALIGN_CHK_EN.
module mem_stage #(
   parameter int XLEN       = 64,
   parameter int DMEM_BYTES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [4:0]            ex_inst_type,
   input  logic [7:0]            ex_opcode,
   input  logic [XLEN-1:0]       ex_rd_data,
   input  logic [XLEN-1:0]       ex_store_data,
   input  logic [4:0]            ex_rd_addr,
   input  logic                  ex_rd_wen,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   output logic [DMEM_BYTES-1:0] dmem_wmask,
   input  logic                  dmem_ack,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic                  wb_valid,
   output logic [4:0]            wb_inst_type,
   output logic [4:0]            wb_rd_addr,
   output logic                  wb_rd_wen,
`ifdef MEM_MISALIGN_CHK_EN
   output logic                  wb_misalign,
`endif
   output logic [XLEN-1:0]       wb_rd_data
);

   localparam logic [7:0] INST_LB  = 8'h10, INST_LH  = 8'h11, INST_LW  = 8'h12, INST_LD = 8'h13;
   localparam logic [7:0] INST_LBU = 8'h14, INST_LHU = 8'h15, INST_LWU = 8'h16;
   localparam logic [7:0] INST_SB  = 8'h18, INST_SH  = 8'h19, INST_SW  = 8'h1A, INST_SD = 8'h1B;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]            state;
   logic [1:0]            size_q;
   logic [2:0]            off_q;
   logic                  sign_q;
   logic [4:0]            type_q;
   logic [4:0]            rd_q;
   logic                  wen_q;

   logic                  is_load, is_store, is_signed;
   logic [1:0]            size_d;
   logic [2:0]            off_d;
   logic [DMEM_BYTES-1:0] mask_base;
   logic [XLEN-1:0]       lane, ld_val;

   assign ex_ready = (state == S_IDLE);
   assign off_d    = ex_rd_data[2:0];

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size_d    = 2'd0;
      case (ex_opcode)
         INST_LB:  begin is_load = 1'b1; is_signed = 1'b1; size_d = 2'd0; end
         INST_LH:  begin is_load = 1'b1; is_signed = 1'b1; size_d = 2'd1; end
         INST_LW:  begin is_load = 1'b1; is_signed = 1'b1; size_d = 2'd2; end
         INST_LD:  begin is_load = 1'b1; is_signed = 1'b1; size_d = 2'd3; end
         INST_LBU: begin is_load = 1'b1; size_d = 2'd0; end
         INST_LHU: begin is_load = 1'b1; size_d = 2'd1; end
         INST_LWU: begin is_load = 1'b1; size_d = 2'd2; end
         INST_SB:  begin is_store = 1'b1; size_d = 2'd0; end
         INST_SH:  begin is_store = 1'b1; size_d = 2'd1; end
         INST_SW:  begin is_store = 1'b1; size_d = 2'd2; end
         INST_SD:  begin is_store = 1'b1; size_d = 2'd3; end
         default:  ;
      endcase
   end

   // Strobes shifted past byte 7 simply fall off the top; no split access.
   always_comb begin
      case (size_d)
         2'd0:    mask_base = DMEM_BYTES'(8'h01);
         2'd1:    mask_base = DMEM_BYTES'(8'h03);
         2'd2:    mask_base = DMEM_BYTES'(8'h0F);
         default: mask_base = DMEM_BYTES'(8'hFF);
      endcase
   end

   always_comb begin
      lane = dmem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    ld_val = sign_q ? {{(XLEN-8){lane[7]}},   lane[7:0]}  : {{(XLEN-8){1'b0}},  lane[7:0]};
         2'd1:    ld_val = sign_q ? {{(XLEN-16){lane[15]}}, lane[15:0]} : {{(XLEN-16){1'b0}}, lane[15:0]};
         2'd2:    ld_val = sign_q ? {{(XLEN-32){lane[31]}}, lane[31:0]} : {{(XLEN-32){1'b0}}, lane[31:0]};
         default: ld_val = lane;
      endcase
   end

`ifdef MEM_MISALIGN_CHK_EN
   logic misaligned;
   always_comb begin
      case (size_d)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = off_d[0];
         2'd2:    misaligned = |off_d[1:0];
         default: misaligned = |off_d;
      endcase
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_wmask   <= '0;
         size_q       <= 2'd0;
         off_q        <= 3'd0;
         sign_q       <= 1'b0;
         type_q       <= 5'd0;
         rd_q         <= 5'd0;
         wen_q        <= 1'b0;
         wb_valid     <= 1'b0;
         wb_inst_type <= 5'd0;
         wb_rd_addr   <= 5'd0;
         wb_rd_wen    <= 1'b0;
         wb_rd_data   <= '0;
`ifdef MEM_MISALIGN_CHK_EN
         wb_misalign  <= 1'b0;
`endif
      end else begin
         wb_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ex_valid) begin
                  if (is_load || is_store) begin
`ifdef MEM_MISALIGN_CHK_EN
                     if (misaligned) begin
                        wb_valid     <= 1'b1;
                        wb_misalign  <= 1'b1;
                        wb_inst_type <= ex_inst_type;
                        wb_rd_addr   <= ex_rd_addr;
                        wb_rd_wen    <= 1'b0;
                        wb_rd_data   <= ex_rd_data;
                     end else
`endif
                     begin
                        state      <= S_WAIT;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {ex_rd_data[XLEN-1:3], 3'b000};
                        dmem_wdata <= is_store ? (ex_store_data << {off_d, 3'b000}) : '0;
                        dmem_wmask <= is_store ? (mask_base << off_d) : '0;
                        size_q     <= size_d;
                        off_q      <= off_d;
                        sign_q     <= is_signed;
                        type_q     <= ex_inst_type;
                        rd_q       <= ex_rd_addr;
                        wen_q      <= ex_rd_wen & ~is_store;
                     end
                  end else begin
                     wb_valid     <= 1'b1;
                     wb_inst_type <= ex_inst_type;
                     wb_rd_addr   <= ex_rd_addr;
                     wb_rd_wen    <= ex_rd_wen;
                     wb_rd_data   <= ex_rd_data;
`ifdef MEM_MISALIGN_CHK_EN
                     wb_misalign  <= 1'b0;
`endif
                  end
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  state        <= S_IDLE;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_inst_type <= type_q;
                  wb_rd_addr   <= rd_q;
                  wb_rd_wen    <= wen_q;
                  wb_rd_data   <= dmem_we ? '0 : ld_val;
`ifdef MEM_MISALIGN_CHK_EN
                  wb_misalign  <= 1'b0;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
// Misalignment checks run when MEM_MISALIGN_CHK_EN is defined.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_inst_type;
   logic [7:0]  ex_opcode;
   logic [63:0] ex_rd_data;
   logic [63:0] ex_store_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_wen;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_inst_type;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_wen;
   logic [63:0] wb_rd_data;
`ifdef MEM_MISALIGN_CHK_EN
   logic        wb_misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_inst_type  (ex_inst_type),
      .ex_opcode     (ex_opcode),
      .ex_rd_data    (ex_rd_data),
      .ex_store_data (ex_store_data),
      .ex_rd_addr    (ex_rd_addr),
      .ex_rd_wen     (ex_rd_wen),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_wmask    (dmem_wmask),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .wb_valid      (wb_valid),
      .wb_inst_type  (wb_inst_type),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_wen     (wb_rd_wen),
`ifdef MEM_MISALIGN_CHK_EN
      .wb_misalign   (wb_misalign),
`endif
      .wb_rd_data    (wb_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [63:0] rd_data,
                        input logic [63:0] st_data, input logic [4:0] rd, input logic wen);
      ex_valid      = v;
      ex_opcode     = op;
      ex_rd_data    = rd_data;
      ex_store_data = st_data;
      ex_rd_addr    = rd;
      ex_rd_wen     = wen;
   endtask

   initial begin
      rst = 1'b1;
      ex_inst_type = 5'd0;
      dmem_ack = 1'b0;
      dmem_rdata = 64'h0;
      drive(1'b0, 8'h00, 64'h0, 64'h0, 5'd0, 1'b0);
      tick();
      tick();
      chk("reset_ex_ready", ex_ready, 1);
      chk("reset_dmem_req", dmem_req, 0);
      chk("reset_dmem_wmask", dmem_wmask, 0);
      chk("reset_wb_valid", wb_valid, 0);
      chk("reset_wb_rd_data", wb_rd_data, 0);
      rst = 1'b0;

      // ADD pass-through, three back-to-back transfers
      ex_inst_type = 5'd3;
      drive(1'b1, 8'h01, 64'h1234, 64'h0, 5'd5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("add_wb_valid", wb_valid, 1);
         chk("add_wb_rd_data", wb_rd_data, 64'h1234);
         chk("add_ex_ready", ex_ready, 1);
      end
      chk("add_wb_rd_addr", wb_rd_addr, 5);
      chk("add_wb_inst_type", wb_inst_type, 3);
`ifdef MEM_MISALIGN_CHK_EN
      chk("add_wb_misalign", wb_misalign, 0);
`endif
      ex_valid = 1'b0;
      tick();
      chk("add_wb_valid_drop", wb_valid, 0);
      chk("add_wb_hold", wb_rd_data, 64'h1234);

      // ack while idle is ignored
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("idle_ack_wb_valid", wb_valid, 0);
      chk("idle_ack_req", dmem_req, 0);

      // LB sign-extend, ack after three request cycles
      dmem_rdata = 64'h0000_0000_8000_0000;
      drive(1'b1, 8'h10, 64'h8000_0003, 64'h0, 5'd7, 1'b1);
      tick();
      ex_valid = 1'b0;
      chk("lb_req", dmem_req, 1);
      chk("lb_addr", dmem_addr, 64'h8000_0000);
      chk("lb_we", dmem_we, 0);
      chk("lb_ex_ready", ex_ready, 0);
      tick();
      tick();
      chk("lb_wait_wb_valid", wb_valid, 0);
      chk("lb_wait_req", dmem_req, 1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("lb_wb_valid", wb_valid, 1);
      chk("lb_wb_rd_data", wb_rd_data, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_wb_rd_wen", wb_rd_wen, 1);
      chk("lb_wb_rd_addr", wb_rd_addr, 7);
      chk("lb_req_drop", dmem_req, 0);
      chk("lb_ex_ready", ex_ready, 1);

      // LBU at minimum latency
      drive(1'b1, 8'h14, 64'h8000_0003, 64'h0, 5'd8, 1'b1);
      tick();
      ex_valid = 1'b0;
      dmem_ack = 1'b1;
      chk("lbu_wb_valid_early", wb_valid, 0);
      tick();
      dmem_ack = 1'b0;
      chk("lbu_wb_valid", wb_valid, 1);
      chk("lbu_wb_rd_data", wb_rd_data, 64'h80);

      // LW signed, upper lane
      dmem_rdata = 64'h8765_4321_0000_0000;
      drive(1'b1, 8'h12, 64'h44, 64'h0, 5'd2, 1'b1);
      tick();
      ex_valid = 1'b0;
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("lw_wb_rd_data", wb_rd_data, 64'hFFFF_FFFF_8765_4321);

      // SH with back-pressure on a following ADD
      drive(1'b1, 8'h19, 64'h0100_0006, 64'hABCD, 5'd4, 1'b1);
      tick();
      drive(1'b1, 8'h01, 64'h55, 64'h0, 5'd9, 1'b1);
      chk("sh_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
      chk("sh_wmask", dmem_wmask, 8'hC0);
      chk("sh_we", dmem_we, 1);
      chk("sh_addr", dmem_addr, 64'h0100_0000);
      chk("bp_ex_ready", ex_ready, 0);
      tick();
      chk("bp_not_consumed", wb_valid, 0);
      chk("sh_wdata_stable", dmem_wdata, 64'hABCD_0000_0000_0000);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("sh_wb_valid", wb_valid, 1);
      chk("sh_wb_rd_wen", wb_rd_wen, 0);
      chk("sh_wb_rd_data", wb_rd_data, 0);
      chk("bp_ex_ready_after", ex_ready, 1);
      tick();
      ex_valid = 1'b0;
      chk("bp_add_wb_valid", wb_valid, 1);
      chk("bp_add_wb_rd_data", wb_rd_data, 64'h55);
      chk("bp_add_wb_rd_addr", wb_rd_addr, 9);
      tick();

`ifndef MEM_MISALIGN_CHK_EN
      // SW crossing the beat boundary: upper lanes dropped
      drive(1'b1, 8'h1A, 64'h206, 64'hDEAD_BEEF, 5'd1, 1'b0);
      tick();
      ex_valid = 1'b0;
      chk("sw_cross_wmask", dmem_wmask, 8'hC0);
      chk("sw_cross_wdata", dmem_wdata, 64'hBEEF_0000_0000_0000);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("sw_cross_wb_valid", wb_valid, 1);
`else
      // misaligned LW traps without a memory request
      drive(1'b1, 8'h12, 64'h2, 64'h0, 5'd6, 1'b1);
      tick();
      ex_valid = 1'b0;
      chk("mis_req", dmem_req, 0);
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_flag", wb_misalign, 1);
      chk("mis_wb_rd_data", wb_rd_data, 64'h2);
      chk("mis_wb_rd_wen", wb_rd_wen, 0);
      chk("mis_ex_ready", ex_ready, 1);
`endif
      tick();

      // async reset while waiting on memory
      drive(1'b1, 8'h13, 64'h300, 64'h0, 5'd3, 1'b1);
      tick();
      ex_valid = 1'b0;
      chk("rstw_req_before", dmem_req, 1);
      rst = 1'b1;
      #1;
      chk("rstw_req_async", dmem_req, 0);
      chk("rstw_wb_valid_async", wb_valid, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("rstw_ex_ready", ex_ready, 1);
      chk("rstw_req_after", dmem_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
